// File: rtl/lab3_dg_keyscan.sv
// 4x4 matrix keypad scanner.
// Drives one column low at a time, debounces press and release of a single key, and emits its hex code with a one-cycle strobe.
module lab3_dg_keyscan #(
    parameter int SCAN_DIV     = 24000,
    parameter int DEBOUNCE_CNT = 40
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       keypress,
    output logic       key_held
);

    // state    | meaning
    // SCAN     | walking columns, one per tick, looking for any low row
    // DEBOUNCE | column frozen, counting ticks with the latched row still low
    // HELD     | key accepted, counting ticks with the latched row high

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t           state, state_n;
    logic [3:0]       rows_meta, rs;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       col, col_n;
    logic [1:0]       row_sel, row_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]       key_n;
    logic             keypress_n, held_n;
    logic             hit, row_level;
    logic [1:0]       hit_row;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Rows are asynchronous pad inputs; two flops before any use.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rs        <= 4'hF;
        end else begin
            rows_meta <= rows;
            rs        <= rows_meta;
        end
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= DIV_LAST;
        else           div_cnt <= div_cnt - 1'b1;
    end

    assign tick = (div_cnt == '0);
    assign cols = ~(4'b0001 << col);

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state    <= SCAN;
            col      <= 2'd0;
            row_sel  <= 2'd0;
            cnt      <= '0;
            key      <= 4'h0;
            keypress <= 1'b0;
            key_held <= 1'b0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            row_sel  <= row_n;
            cnt      <= cnt_n;
            key      <= key_n;
            keypress <= keypress_n;
            key_held <= held_n;
        end
    end

    always_comb begin
        hit        = ~&rs;
        hit_row    = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
        row_level  = rs[row_sel];
        cnt_inc    = (cnt == CNT_DONE) ? cnt : cnt + 1'b1;
        state_n    = state;
        col_n      = col;
        row_n      = row_sel;
        cnt_n      = cnt;
        key_n      = key;
        keypress_n = 1'b0;
        held_n     = key_held;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (hit) begin
                        row_n   = hit_row;
                        cnt_n   = CNT_W'(1);
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!row_level) begin
                        if (cnt_inc == CNT_DONE) begin
                            key_n      = key_map(row_sel, col);
                            keypress_n = 1'b1;
                            held_n     = 1'b1;
                            cnt_n      = '0;
                            state_n    = HELD;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        cnt_n   = '0;
                        col_n   = col + 2'd1;
                        state_n = SCAN;
                    end
                end
            end
            HELD: begin
                // Any other key is invisible here: only the latched row is watched.
                if (tick) begin
                    if (row_level) begin
                        if (cnt_inc == CNT_DONE) begin
                            held_n  = 1'b0;
                            cnt_n   = '0;
                            col_n   = col + 2'd1;
                            state_n = SCAN;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
            end
            default: state_n = SCAN;
        endcase
    end

endmodule

// File: tb/tb_lab3_dg_keyscan.sv
// Self-checking bench for lab3_dg_keyscan with a keypad matrix model, directed vectors and random presses.
module tb_lab3_dg_keyscan;

    logic        int_osc;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        keypress;
    logic        key_held;

    logic [15:0] pressed;   // bit r*4+c = key at row r / column c is down
    int          n_cmp = 0;
    int          n_err = 0;
    int          strobe_cnt = 0;
    logic        kp_prev = 1'b0;
    logic        rand_on = 1'b0;
    logic [3:0]  exp_q[$];

    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'hE, 4'h0, 4'hF, 4'hD};

    typedef struct {
        logic [15:0] pressed;
        int          cycles;
        int          strobes;
        logic [3:0]  key;
        logic        held;
        logic        chk_cols;
        logic [3:0]  cols;
    } vec_t;

    vec_t vecs[8];

    lab3_dg_keyscan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .int_osc  (int_osc),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key      (key),
        .keypress (keypress),
        .key_held (key_held)
    );

    initial int_osc = 1'b0;
    always #5 int_osc = ~int_osc;

    // A row reads low when any pressed key on it sits in a driven (low) column.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge int_osc) begin
        if (keypress === 1'b1) begin
            check("strobe_one_cycle", {31'd0, kp_prev}, 32'd0);
            strobe_cnt++;
            if (rand_on) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_strobe", {28'd0, key}, 32'hFFFF);
                end else begin
                    check("rand_key", {28'd0, key}, {28'd0, exp_q.pop_front()});
                end
            end
        end
        kp_prev = keypress;
    end

    initial begin
        logic [3:0] prev_cols;
        int         gap, changes, s0, k, hold, run;
        logic       found;

        vecs[0] = '{16'h0040, 40, 1, 4'h6, 1'b1, 1'b1, 4'b1011};
        vecs[1] = '{16'h0000, 20, 0, 4'h6, 1'b0, 1'b0, 4'b0000};
        vecs[2] = '{16'h8000, 40, 1, 4'hD, 1'b1, 1'b1, 4'b0111};
        vecs[3] = '{16'h8001, 40, 0, 4'hD, 1'b1, 1'b1, 4'b0111};
        vecs[4] = '{16'h0001, 60, 1, 4'h1, 1'b1, 1'b1, 4'b1110};
        vecs[5] = '{16'h0000, 20, 0, 4'h1, 1'b0, 1'b0, 4'b0000};
        vecs[6] = '{16'h0020,  6, 0, 4'h1, 1'b0, 1'b0, 4'b0000};
        vecs[7] = '{16'h0000, 20, 0, 4'h1, 1'b0, 1'b0, 4'b0000};

        pressed = 16'h0;
        reset   = 1'b1;
        repeat (3) @(negedge int_osc);
        check("rst_cols", {28'd0, cols}, 32'hE);
        check("rst_key", {28'd0, key}, 32'h0);
        check("rst_keypress", {31'd0, keypress}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);

        reset = 1'b0;
        prev_cols = cols;
        gap = 0;
        changes = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge int_osc);
            gap++;
            if (cols !== prev_cols) begin
                check("walk_next", {28'd0, cols}, {28'd0, prev_cols[2:0], prev_cols[3]});
                if (changes > 0) check("walk_gap", gap, 4);
                changes++;
                gap = 0;
                prev_cols = cols;
            end
        end
        check("walk_changes", {31'd0, changes >= 5}, 32'd1);

        foreach (vecs[i]) begin
            pressed = vecs[i].pressed;
            s0 = strobe_cnt;
            repeat (vecs[i].cycles) @(negedge int_osc);
            check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, vecs[i].strobes);
            check($sformatf("vec%0d_key", i), {28'd0, key}, {28'd0, vecs[i].key});
            check($sformatf("vec%0d_held", i), {31'd0, key_held}, {31'd0, vecs[i].held});
            if (vecs[i].chk_cols)
                check($sformatf("vec%0d_cols", i), {28'd0, cols}, {28'd0, vecs[i].cols});
        end

        // Bounce on '6': toggle every scan period, then settle low.
        s0 = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            repeat (4) @(negedge int_osc);
        end
        check("bounce_no_strobe", strobe_cnt - s0, 0);
        check("bounce_key_kept", {28'd0, key}, 32'h1);
        pressed = 16'h0040;
        repeat (40) @(negedge int_osc);
        check("bounce_one_strobe", strobe_cnt - s0, 1);
        check("bounce_key", {28'd0, key}, 32'h6);
        pressed = 16'h0000;
        repeat (20) @(negedge int_osc);

        // Reset while debouncing '5': wait for column 1 to stay driven past one scan period.
        pressed = 16'h0020;
        run = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge int_osc);
            run = (cols === 4'b1101) ? run + 1 : 0;
            if (run >= 5) found = 1'b1;
        end
        check("mid_debounce_reached", {31'd0, found}, 32'd1);
        s0 = strobe_cnt;
        reset = 1'b1;
        #1;
        check("mid_rst_cols", {28'd0, cols}, 32'hE);
        check("mid_rst_key", {28'd0, key}, 32'h0);
        check("mid_rst_keypress", {31'd0, keypress}, 32'd0);
        check("mid_rst_held", {31'd0, key_held}, 32'd0);
        pressed = 16'h0000;
        repeat (2) @(negedge int_osc);
        reset = 1'b0;
        repeat (30) @(negedge int_osc);
        check("mid_rst_no_strobe", strobe_cnt - s0, 0);
        check("mid_rst_key_after", {28'd0, key}, 32'h0);

        // Random single-key presses and short glitches against a strobe queue.
        rand_on = 1'b1;
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                hold = $urandom_range(1, 6);
                pressed = 16'h1 << k;
                repeat (hold) @(negedge int_osc);
                pressed = 16'h0;
                repeat (20) @(negedge int_osc);
                check("rand_glitch_not_held", {31'd0, key_held}, 32'd0);
            end else begin
                hold = $urandom_range(40, 55);
                exp_q.push_back(KEYMAP[k]);
                pressed = 16'h1 << k;
                repeat (hold) @(negedge int_osc);
                check("rand_held", {31'd0, key_held}, 32'd1);
                check("rand_key_level", {28'd0, key}, {28'd0, KEYMAP[k]});
                pressed = 16'h0;
                repeat ($urandom_range(20, 30)) @(negedge int_osc);
                check("rand_released", {31'd0, key_held}, 32'd0);
            end
        end
        rand_on = 1'b0;
        check("rand_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
